// File: rtl/bram_pair_reader.sv
// Burst reader for one side of the ping-pong matrix BRAM: fetches word pairs
// (even word on port A, odd word on port B) and streams them out on valid/ready.
module bram_pair_reader #(
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_SIZE   = 128,
    parameter int DATA_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic                  en_a,
    output logic                  we_a,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] dout_a,
    output logic                  en_b,
    output logic                  we_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] din_b,
    input  logic [DATA_WIDTH-1:0] dout_b,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data_a,
    output logic [DATA_WIDTH-1:0] m_data_b,
    output logic                  m_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                         state_q;
    logic [ADDR_WIDTH-1:0]          len_q, issue_cnt_q, accept_cnt_q;
    logic [ADDR_WIDTH-1:0]          addr_a_q, addr_b_q;
    logic                           rvld_q, rlast_q, done_q;
    logic [1:0][DATA_WIDTH-1:0]     fa_q, fb_q;
    logic [1:0]                     fl_q;
    logic                           wr_ptr_q, rd_ptr_q;
    logic [1:0]                     cnt_q, cnt_d;
    logic                           push, pop, issue, last_issue;
    logic [2:0]                     outstanding;

    function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [ADDR_WIDTH-1:0] step);
        logic [ADDR_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, step};
        if (s >= (ADDR_WIDTH+1)'(MEM_SIZE))
            s = s - (ADDR_WIDTH+1)'(MEM_SIZE);
        return s[ADDR_WIDTH-1:0];
    endfunction

    assign push    = rvld_q;
    assign m_valid = (cnt_q != 2'd0);
    assign pop     = m_valid && m_ready;
    assign cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};

    // A pop in this cycle frees a slot, so one pair per cycle sustains with m_ready high.
    assign outstanding = {1'b0, cnt_q} + {2'b0, rvld_q} - {2'b0, pop};
    assign issue       = (state_q == RUN) && (issue_cnt_q < len_q) && (outstanding < 3'd2);
    assign last_issue  = (issue_cnt_q == len_q - ADDR_WIDTH'(1));

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign en_a     = issue;
    assign en_b     = issue;
    assign we_a     = 1'b0;
    assign we_b     = 1'b0;
    assign din_a    = '0;
    assign din_b    = '0;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign m_data_a = fa_q[rd_ptr_q];
    assign m_data_b = fb_q[rd_ptr_q];
    assign m_last   = m_valid && fl_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            rvld_q       <= 1'b0;
            rlast_q      <= 1'b0;
            done_q       <= 1'b0;
            fa_q         <= '0;
            fb_q         <= '0;
            fl_q         <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            done_q  <= 1'b0;
            rvld_q  <= issue;
            rlast_q <= last_issue;
            cnt_q   <= cnt_d;

            if (push) begin
                fa_q[wr_ptr_q] <= dout_a;
                fb_q[wr_ptr_q] <= dout_b;
                fl_q[wr_ptr_q] <= rlast_q;
                wr_ptr_q       <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            len_q        <= len;
                            issue_cnt_q  <= '0;
                            accept_cnt_q <= '0;
                            addr_a_q     <= base_addr;
                            addr_b_q     <= wrap_add(base_addr, ADDR_WIDTH'(1));
                            state_q      <= RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Addresses point at the next pair to issue and hold while stalled.
                    if (issue) begin
                        issue_cnt_q <= issue_cnt_q + ADDR_WIDTH'(1);
                        addr_a_q    <= wrap_add(addr_a_q, ADDR_WIDTH'(2));
                        addr_b_q    <= wrap_add(addr_b_q, ADDR_WIDTH'(2));
                    end
                    if (pop) begin
                        accept_cnt_q <= accept_cnt_q + ADDR_WIDTH'(1);
                        if (accept_cnt_q == len_q - ADDR_WIDTH'(1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
